mmss_counter: RTL and testbench
===============================

# mmss_counter

Minutes:seconds timekeeping stage that consumes the single-cycle 1 Hz tick produced by the divider stage and maintains a BCD MM:SS count. It provides pause, a manual adjust mode driven by a faster adjust tick, and a rollover pulse. Its four BCD digits feed the seven-segment display multiplexer directly.

## Interface
- MIN_WRAP, 60, minute modulus; minutes count 0..MIN_WRAP-1; legal range 1..100
- clk  in  1  system clock (100 MHz)
- rst  in  1  asynchronous, active-high reset
- tick  in  1  one-cycle 1 Hz count strobe from the divider
- tick_adj  in  1  one-cycle adjust strobe (2 Hz nominal)
- pause  in  1  level; holds the count while high (run mode only)
- adj  in  1  level; selects adjust mode
- sel  in  1  adjust target: 0 = seconds, 1 = minutes
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD digits
- wrap  out  1  one-cycle pulse on MM:SS rollover to 00:00
- blank  out  4  per-digit blank mask {min_tens, min_ones, sec_tens, sec_ones}

## Operation
- Modes are decoded each cycle: ADJUST when adj=1; otherwise PAUSED when pause=1; otherwise RUN.
- RUN, on tick:
  - sec_ones increments; 9 becomes 0 with a carry into sec_tens.
  - Seconds 59 becomes 00 with a carry into minutes.
  - Minutes MIN_WRAP-1 becomes 00.
  - A full rollover from (MIN_WRAP-1):59 to 00:00 asserts wrap.
- PAUSED: tick is ignored and the digits hold.
- ADJUST:
  - tick is ignored; pause has no effect.
  - On tick_adj, the sel field increments by 1 modulo its range: seconds 60, minutes MIN_WRAP.
  - There is no carry between fields and wrap is never asserted.
- Simultaneous tick and tick_adj: only the strobe belonging to the current mode acts; the other is dropped, not deferred.
- sel and adj changes take effect on the first clock edge at which they are sampled; there is no glitch or partial increment.
- Digits always hold legal BCD: each digit 0..9, sec_tens 0..5, minutes < MIN_WRAP.

## Timing
- All outputs are registered. Digits update on the clock edge that samples the strobe high, so latency is 1 cycle.
- wrap is high for exactly the one cycle in which the digits first read 00:00 after rollover.
- The strobes are assumed synchronous to clk and one cycle wide. A strobe held high N cycles produces N increments.
- Reset values (asserted asynchronously, released synchronously by the source): all digits 0, wrap 0, blank 4'b0000, blink phase 0.
- Reset mid-count clears immediately. The first tick after release produces 00:01.

## Configuration
- ADJ_BLINK_EN defined:
  - A blink-phase flop toggles on every tick while adj=1 and clears when adj=0.
  - While the phase is 1, blank asserts on the two digits of the sel field: 4'b0011 for seconds, 4'b1100 for minutes.
  - A sel change mid-adjust moves the mask on the next cycle and does not reset the phase.
- ADJ_BLINK_EN undefined: blank is tied to 4'b0000 and no phase flop exists.

## Structure
- Shared package clk_pkg: BCD digit typedef (4 bits), SEC_WRAP = 60, mode encodings (RUN, PAUSED, ADJUST), blank mask constants.
- Sub-module bcd_mod_counter: two-digit BCD counter with a modulus parameter, inc input, and carry-out on wrap. Instantiated twice: seconds with modulus 60, minutes with modulus MIN_WRAP.
- This top level holds mode decode, strobe steering, the wrap register, and the optional blink logic.

## Test plan
- Reset mid-count: at 12:34, assert rst asynchronously mid-cycle → digits read 00:00 without waiting for a clock edge; wrap=0; blank=0.
- Seconds carry: from 00:00, 59 ticks → 00:59; one more tick → 01:00 one cycle later; wrap stays 0.
- Rollover: with MIN_WRAP=60, preset 59:59 via adjust, set adj=0, then tick → 00:00 and wrap high for exactly 1 cycle. Repeat with MIN_WRAP=10 from 09:59.
- Pause: pause=1 with 10 ticks → digits unchanged. Release pause, then tick → count increments by 1.
- Adjust isolation: adj=1, sel=0 at 03:59, tick_adj together with tick → 03:00; minutes unchanged; wrap=0. Set sel=1, then 57 tick_adj → 00:00 (03+57=60, wraps to 00).
- Blink (ADJ_BLINK_EN): adj=1, sel=1, tick → blank=4'b1100; next tick → 4'b0000. Set adj=0 → blank=4'b0000 and phase cleared.

Source files
------------

// File: rtl/clk_pkg.sv
// ---------------------------------------------------------------------------
// clk_pkg
//   Shared definitions for the clock display pipeline:
//     - bcd_t      : one BCD digit (4 bits)
//     - SEC_WRAP   : seconds modulus
//     - mode_e     : operating modes of the MM:SS stage (RUN, PAUSED, ADJUST)
//     - BLANK_*    : per-digit blank masks {min_tens, min_ones, sec_tens, sec_ones}
//     - decode_mode: priority decode of the adj / pause levels
// ---------------------------------------------------------------------------
package clk_pkg;

    typedef logic [3:0] bcd_t;

    localparam int SEC_WRAP = 60;

    typedef enum logic [1:0] {
        MODE_RUN    = 2'd0,
        MODE_PAUSED = 2'd1,
        MODE_ADJUST = 2'd2
    } mode_e;

    localparam logic [3:0] BLANK_NONE = 4'b0000;
    localparam logic [3:0] BLANK_SEC  = 4'b0011;
    localparam logic [3:0] BLANK_MIN  = 4'b1100;

    // Adjust wins over pause; pause only matters in run mode.
    function automatic mode_e decode_mode(input logic adj, input logic pause);
        mode_e m;
        if (adj) begin
            m = MODE_ADJUST;
        end else if (pause) begin
            m = MODE_PAUSED;
        end else begin
            m = MODE_RUN;
        end
        return m;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// ---------------------------------------------------------------------------
// bcd_mod_counter
//   Two-digit BCD counter counting 0 .. MOD-1 (MOD legal range 1..100).
//   Increments on every cycle with inc_i high; at MOD-1 it returns to 00 and
//   raises carry_o combinationally in that same cycle so a following stage
//   can increment on the same clock edge.
//
//   Ports:
//     clk     in   system clock
//     rst     in   asynchronous active-high reset (digits -> 00)
//     inc_i   in   increment enable
//     tens_o  out  tens digit (registered)
//     ones_o  out  ones digit (registered)
//     carry_o out  inc_i while the count sits at MOD-1 (wrap this edge)
// ---------------------------------------------------------------------------
module bcd_mod_counter
    import clk_pkg::*;
#(
    parameter int MOD = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o,
    output logic       carry_o
);

    localparam int   MAX_VAL  = MOD - 1;
    localparam bcd_t MAX_TENS = bcd_t'(MAX_VAL / 10);
    localparam bcd_t MAX_ONES = bcd_t'(MAX_VAL % 10);

    bcd_t tens_q, tens_d;
    bcd_t ones_q, ones_d;
    logic at_max;

    assign at_max  = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
    assign carry_o = inc_i && at_max;

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (inc_i) begin
            if (at_max) begin
                tens_d = 4'd0;
                ones_d = 4'd0;
            end else if (ones_q == 4'd9) begin
                tens_d = tens_q + 4'd1;
                ones_d = 4'd0;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens_q <= 4'd0;
            ones_q <= 4'd0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens_o = tens_q;
    assign ones_o = ones_q;

endmodule

// File: rtl/mmss_counter.sv
// ---------------------------------------------------------------------------
// mmss_counter
//   BCD MM:SS timekeeping stage. Counts the 1 Hz tick in run mode, holds in
//   pause, and in adjust mode steps the selected field (seconds or minutes)
//   on the adjust strobe without inter-field carry. wrap pulses for the one
//   cycle in which the digits first read 00:00 after a full rollover.
//
//   Optional feature macro: ADJ_BLINK_EN
//     defined   : a blink phase toggles on each tick while adj=1; while it is
//                 1 the digits of the selected field are blanked.
//     undefined : blank is constant 4'b0000, no phase flop.
//
//   Parameters:
//     MIN_WRAP  minute modulus (1..100), minutes count 0..MIN_WRAP-1
//
//   Ports:
//     clk       in   system clock
//     rst       in   asynchronous active-high reset
//     tick      in   one-cycle 1 Hz count strobe
//     tick_adj  in   one-cycle adjust strobe
//     pause     in   hold count (run mode only)
//     adj       in   adjust mode select
//     sel       in   adjust target: 0 = seconds, 1 = minutes
//     min_tens, min_ones, sec_tens, sec_ones  out  BCD digits (registered)
//     wrap      out  rollover pulse (registered)
//     blank     out  per-digit blank mask {min_tens,min_ones,sec_tens,sec_ones}
//
//   Strobe handshake: tick and tick_adj are plain one-cycle enables, each
//   high cycle is consumed on the clock edge that samples it; a strobe not
//   belonging to the current mode is dropped, never queued.
// ---------------------------------------------------------------------------
module mmss_counter
    import clk_pkg::*;
#(
    parameter int MIN_WRAP = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       tick_adj,
    input  logic       pause,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       wrap,
    output logic [3:0] blank
);

    mode_e mode;
    logic  run_tick;
    logic  adj_tick;
    logic  sec_inc;
    logic  min_inc;
    logic  sec_carry;
    logic  min_carry;
    logic  wrap_q, wrap_d;

    assign mode     = decode_mode(adj, pause);
    assign run_tick = (mode == MODE_RUN) && tick;
    assign adj_tick = (mode == MODE_ADJUST) && tick_adj;

    // In adjust mode only the selected field moves and carries are ignored.
    assign sec_inc = run_tick || (adj_tick && !sel);
    assign min_inc = (run_tick && sec_carry) || (adj_tick && sel);

    // Full rollover only counts when it came from the 1 Hz chain.
    assign wrap_d = run_tick && sec_carry && min_carry;

    bcd_mod_counter #(
        .MOD (SEC_WRAP)
    ) u_sec (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (sec_inc),
        .tens_o  (sec_tens),
        .ones_o  (sec_ones),
        .carry_o (sec_carry)
    );

    bcd_mod_counter #(
        .MOD (MIN_WRAP)
    ) u_min (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (min_inc),
        .tens_o  (min_tens),
        .ones_o  (min_ones),
        .carry_o (min_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;

`ifdef ADJ_BLINK_EN
    logic       phase_q, phase_d;
    logic [3:0] blank_q, blank_d;

    // Mask is built from the next phase and the currently sampled sel so the
    // registered mask lines up with the phase flop and follows sel one edge
    // later without touching the phase.
    always_comb begin
        phase_d = 1'b0;
        if (mode == MODE_ADJUST) begin
            phase_d = phase_q ^ tick;
        end
        blank_d = BLANK_NONE;
        if (phase_d) begin
            blank_d = sel ? BLANK_MIN : BLANK_SEC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= 1'b0;
            blank_q <= BLANK_NONE;
        end else begin
            phase_q <= phase_d;
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`else
    assign blank = BLANK_NONE;
`endif

endmodule

// File: tb/tb_mmss_counter.sv
// ---------------------------------------------------------------------------
// tb_mmss_counter
//   Directed bench for mmss_counter. Two instances share all inputs: one with
//   the default minute modulus 60 and one with MIN_WRAP=10. Digits are
//   compared as a 16-bit BCD word {min_tens,min_ones,sec_tens,sec_ones}.
//   Inputs change at negedge, outputs are sampled at negedge.
// ---------------------------------------------------------------------------
module tb_mmss_counter;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       tick_adj;
    logic       pause;
    logic       adj;
    logic       sel;

    logic [3:0] a_mt, a_mo, a_st, a_so, a_blank;
    logic       a_wrap;
    logic [3:0] b_mt, b_mo, b_st, b_so, b_blank;
    logic       b_wrap;

    logic [15:0] a_digits;
    logic [15:0] b_digits;

    int checks;
    int errors;

    assign a_digits = {a_mt, a_mo, a_st, a_so};
    assign b_digits = {b_mt, b_mo, b_st, b_so};

    mmss_counter u_dut60 (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .tick_adj (tick_adj),
        .pause    (pause),
        .adj      (adj),
        .sel      (sel),
        .min_tens (a_mt),
        .min_ones (a_mo),
        .sec_tens (a_st),
        .sec_ones (a_so),
        .wrap     (a_wrap),
        .blank    (a_blank)
    );

    mmss_counter #(
        .MIN_WRAP (10)
    ) u_dut10 (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .tick_adj (tick_adj),
        .pause    (pause),
        .adj      (adj),
        .sel      (sel),
        .min_tens (b_mt),
        .min_ones (b_mo),
        .sec_tens (b_st),
        .sec_ones (b_so),
        .wrap     (b_wrap),
        .blank    (b_blank)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; holds tick high for n consecutive cycles.
    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            @(negedge clk);
        end
        tick = 1'b0;
    endtask

    task automatic adj_tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick_adj = 1'b1;
            @(negedge clk);
        end
        tick_adj = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        tick     = 1'b0;
        tick_adj = 1'b0;
        pause    = 1'b0;
        adj      = 1'b0;
        sel      = 1'b0;

        // Reset state
        idle(2);
        check("reset_digits60", a_digits, 16'h0000);
        check("reset_digits10", b_digits, 16'h0000);
        check("reset_wrap", {15'd0, a_wrap}, 16'd0);
        check("reset_blank", {12'd0, a_blank}, 16'd0);
        rst = 1'b0;
        idle(1);

        // Seconds carry
        tick_n(59);
        check("sec59_60", a_digits, 16'h0059);
        check("sec59_10", b_digits, 16'h0059);
        tick_n(1);
        check("carry_min60", a_digits, 16'h0100);
        check("carry_min10", b_digits, 16'h0100);
        check("carry_nowrap", {15'd0, a_wrap}, 16'd0);

        // Pause holds, release counts one
        pause = 1'b1;
        tick_n(10);
        check("pause_hold", a_digits, 16'h0100);
        pause = 1'b0;
        tick_n(1);
        check("pause_release", a_digits, 16'h0101);

        // tick_adj in run mode is dropped
        adj_tick_n(1);
        check("run_ignores_adj", a_digits, 16'h0101);

        // Preset 12:34 via adjust (dut10 minutes: 1+11 mod 10 = 2)
        adj = 1'b1;
        sel = 1'b1;
        adj_tick_n(11);
        sel = 1'b0;
        adj_tick_n(33);
        check("preset_1234", a_digits, 16'h1234);
        check("preset_0234", b_digits, 16'h0234);

        // Asynchronous reset mid-cycle, no clock edge in between
        #2 rst = 1'b1;
        #1;
        check("async_rst60", a_digits, 16'h0000);
        check("async_rst10", b_digits, 16'h0000);
        check("async_rst_wrap", {15'd0, a_wrap}, 16'd0);
        check("async_rst_blank", {12'd0, a_blank}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        adj = 1'b0;
        tick_n(1);
        check("first_tick", a_digits, 16'h0001);

        // Preset 03:59
        adj = 1'b1;
        sel = 1'b1;
        adj_tick_n(3);
        sel = 1'b0;
        adj_tick_n(58);
        check("preset_0359", a_digits, 16'h0359);

        // pause has no effect in adjust mode
        pause = 1'b1;
        tick_n(3);
        check("adj_ignores_tick", a_digits, 16'h0359);
        pause = 1'b0;

        // Adjust isolation: both strobes together, seconds wrap without carry
        tick     = 1'b1;
        tick_adj = 1'b1;
        @(negedge clk);
        tick     = 1'b0;
        tick_adj = 1'b0;
        check("adj_iso60", a_digits, 16'h0300);
        check("adj_iso10", b_digits, 16'h0300);
        check("adj_iso_wrap", {15'd0, a_wrap}, 16'd0);
        sel = 1'b1;
        adj_tick_n(57);
        check("adj_min_wrap60", a_digits, 16'h0000);
        check("adj_min_wrap10", b_digits, 16'h0000);
        check("adj_never_wrap", {15'd0, a_wrap | b_wrap}, 16'd0);

        // Rollover: 59:59 on dut60, 09:59 on dut10
        adj_tick_n(59);
        sel = 1'b0;
        adj_tick_n(59);
        check("preset_5959", a_digits, 16'h5959);
        check("preset_0959", b_digits, 16'h0959);
        adj = 1'b0;
        idle(1);
        tick_n(1);
        check("roll60_digits", a_digits, 16'h0000);
        check("roll10_digits", b_digits, 16'h0000);
        check("roll60_wrap", {15'd0, a_wrap}, 16'd1);
        check("roll10_wrap", {15'd0, b_wrap}, 16'd1);
        idle(1);
        check("roll60_wrap_end", {15'd0, a_wrap}, 16'd0);
        check("roll10_wrap_end", {15'd0, b_wrap}, 16'd0);

        // Blink behaviour
        adj = 1'b1;
        sel = 1'b1;
        tick_n(1);
`ifdef ADJ_BLINK_EN
        check("blink_min_on", {12'd0, a_blank}, {12'd0, 4'b1100});
        tick_n(1);
        check("blink_min_off", {12'd0, a_blank}, 16'd0);
        tick_n(1);
        check("blink_min_on2", {12'd0, a_blank}, {12'd0, 4'b1100});
        sel = 1'b0;
        idle(1);
        check("blink_sel_move", {12'd0, a_blank}, {12'd0, 4'b0011});
        adj = 1'b0;
        idle(1);
        check("blink_adj_off", {12'd0, a_blank}, 16'd0);
        // Phase cleared: re-entering adjust, the first tick turns blank on
        adj = 1'b1;
        tick_n(1);
        check("blink_phase_clr", {12'd0, a_blank}, {12'd0, 4'b0011});
`else
        check("blank_tied", {12'd0, a_blank}, 16'd0);
        tick_n(1);
        check("blank_tied2", {12'd0, a_blank}, 16'd0);
`endif
        check("blink_digits", a_digits, 16'h0000);
        adj = 1'b0;
        idle(1);

        // Strobe held N cycles gives N increments
        tick_n(5);
        check("held_tick", a_digits, 16'h0005);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
